permutation_ctrl: RTL and testbench

- Round sequencer that drives the Ascon permutation datapath through one complete permutation p^a or p^b.
- Accepts a start request with a round-count mode. Drives select, round index and enable to the datapath, then reports completion with a one-cycle done pulse.
- Sits between the top-level Ascon mode FSM (initialisation, associated data, plaintext, finalisation) and the permutation round datapath.
- Supports a hold (stall) and a synchronous abort.

---
 rtl/permutation_ctrl.sv | 76 +++++++
 tb/tb_permutation_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/permutation_ctrl.sv
// permutation_ctrl: sequences the Ascon permutation datapath through one p^a or p^b run.
// Ports: clock_i/resetb_i (async active-low); start_i, mode_i (0=p^a, 1=p^b), hold_i, abort_i;
// select_o (load external state), round_o (round-constant index), enable_o (state update),
// busy_o (RUN), ready_o (start accepted), done_o (one-cycle completion pulse).
module permutation_ctrl #(
   parameter int ROUNDS_A = 12,
   parameter int ROUNDS_B = 6
) (
   input  logic       clock_i,
   input  logic       resetb_i,
   input  logic       start_i,
   input  logic       mode_i,
   input  logic       hold_i,
   input  logic       abort_i,
   output logic       select_o,
   output logic [3:0] round_o,
   output logic       enable_o,
   output logic       busy_o,
   output logic       ready_o,
   output logic       done_o
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   // Rounds always finish at index 11, so a run of n rounds starts at 12-n.
   localparam logic [3:0] START_A = 4'(12 - ROUNDS_A);
   localparam logic [3:0] START_B = 4'(12 - ROUNDS_B);
   if (ROUNDS_A < 1 || ROUNDS_A > 12) begin : g_bad_a
      $error("ROUNDS_A must be 1..12");
   end
   if (ROUNDS_B < 1 || ROUNDS_B > 12) begin : g_bad_b
      $error("ROUNDS_B must be 1..12");
   end
   state_t     state, state_d;
   logic [3:0] cnt, cnt_d;
   logic       first, first_d;
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state <= IDLE;
         cnt   <= '0;
         first <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         first <= first_d;
      end
   end
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      first_d = first;
      if (abort_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         first_d = 1'b0;
      end else if (state == RUN) begin
         if (!hold_i) begin
            first_d = 1'b0;
            state_d = (cnt == 4'd11) ? DONE : RUN;
            cnt_d   = (cnt == 4'd11) ? cnt : cnt + 4'd1;
         end
      end else if (start_i) begin
         state_d = RUN;
         cnt_d   = mode_i ? START_B : START_A;
         first_d = 1'b1;
      end else begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end
   assign busy_o   = state == RUN;
   assign ready_o  = state != RUN;
   assign done_o   = state == DONE;
   // hold_i gates the datapath update directly so a stall takes effect in the same cycle.
   assign enable_o = busy_o & ~hold_i;
   assign select_o = busy_o & first & ~hold_i;
   assign round_o  = busy_o ? cnt : (done_o ? 4'd11 : 4'd0);
endmodule

// File: tb/tb_permutation_ctrl.sv
// tb_permutation_ctrl: vector table plus hand sequences for permutation_ctrl.
module tb_permutation_ctrl;
   logic clock_i = 1'b0, resetb_i = 1'b0;
   logic start_i = 1'b0, mode_i = 1'b0, hold_i = 1'b0, abort_i = 1'b0;
   logic select_o, enable_o, busy_o, ready_o, done_o;
   logic [3:0] round_o;
   logic s1, e1, b1, r1, d1;
   logic [3:0] rd1;
   int n_cmp = 0, n_bad = 0;
   typedef struct {
      logic start, mode, hold, abort;
      logic [8:0] exp;
      string name;
   } vec_t;
   vec_t tbl[$];
   logic [8:0] sb[$];

   permutation_ctrl u_dut (
      .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .mode_i(mode_i),
      .hold_i(hold_i), .abort_i(abort_i), .select_o(select_o), .round_o(round_o),
      .enable_o(enable_o), .busy_o(busy_o), .ready_o(ready_o), .done_o(done_o));

   permutation_ctrl #(.ROUNDS_A(1), .ROUNDS_B(12)) u_dut1 (
      .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .mode_i(mode_i),
      .hold_i(hold_i), .abort_i(abort_i), .select_o(s1), .round_o(rd1),
      .enable_o(e1), .busy_o(b1), .ready_o(r1), .done_o(d1));

   always #5 clock_i = ~clock_i;

   // Output vector layout: {select, round[3:0], enable, busy, ready, done}
   function automatic logic [8:0] e_idle();
      return 9'b0_0000_0_0_1_0;
   endfunction
   function automatic logic [8:0] e_done();
      return 9'b0_1011_0_0_1_1;
   endfunction
   function automatic logic [8:0] e_run(input int r, input logic f);
      return {f, 4'(r), 1'b1, 1'b1, 1'b0, 1'b0};
   endfunction
   function automatic logic [8:0] e_hold(input int r);
      return {1'b0, 4'(r), 1'b0, 1'b1, 1'b0, 1'b0};
   endfunction
   function automatic void add(input logic st, md, hd, ab, input logic [8:0] e, input string nm);
      tbl.push_back('{st, md, hd, ab, e, nm});
   endfunction

   task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b (sel,round,en,busy,ready,done)", nm, act, exp);
      end
   endtask

   task automatic run_table();
      while (tbl.size() > 0) begin
         vec_t v;
         v = tbl.pop_front();
         @(posedge clock_i);
         #1;
         {start_i, mode_i, hold_i, abort_i} = {v.start, v.mode, v.hold, v.abort};
         sb.push_back(v.exp);
         @(negedge clock_i);
         check(v.name, {select_o, round_o, enable_o, busy_o, ready_o, done_o}, sb.pop_front());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required end before 100000");
      $fatal(1);
   end

   initial begin
      @(negedge clock_i);
      check("reset", {select_o, round_o, enable_o, busy_o, ready_o, done_o}, e_idle());
      #2 resetb_i = 1'b1;
      // p^a unstalled
      add(0, 0, 0, 0, e_idle(), "idle");
      add(1, 0, 0, 0, e_idle(), "pa_accept");
      for (int i = 0; i < 12; i++) add(0, 0, 0, 0, e_run(i, i == 0), "pa_run");
      add(0, 0, 0, 0, e_done(), "pa_done");
      add(0, 0, 0, 0, e_idle(), "pa_idle");
      // p^b, mode_i flipped after acceptance
      add(1, 1, 0, 0, e_idle(), "pb_accept");
      for (int i = 6; i < 12; i++) add(0, 0, 0, 0, e_run(i, i == 6), "pb_run");
      add(0, 0, 0, 0, e_done(), "pb_done");
      add(0, 0, 0, 0, e_idle(), "pb_idle");
      // p^a with 3-cycle hold at round 4, hold ignored in DONE
      add(1, 0, 0, 0, e_idle(), "hold_accept");
      for (int i = 0; i < 12; i++) begin
         if (i == 4) for (int k = 0; k < 3; k++) add(0, 0, 1, 0, e_hold(4), "hold_stall");
         add(0, 0, 0, 0, e_run(i, i == 0), "hold_run");
      end
      add(0, 0, 1, 0, e_done(), "hold_done");
      add(0, 0, 0, 0, e_idle(), "hold_idle");
      // start held high: back-to-back p^b
      add(1, 1, 0, 0, e_idle(), "b2b_accept");
      for (int i = 6; i < 12; i++) add(1, 1, 0, 0, e_run(i, i == 6), "b2b_run1");
      add(1, 1, 0, 0, e_done(), "b2b_done1");
      for (int i = 6; i < 12; i++) add(1, 1, 0, 0, e_run(i, i == 6), "b2b_run2");
      add(0, 1, 0, 0, e_done(), "b2b_done2");
      add(0, 1, 0, 0, e_idle(), "b2b_idle");
      // abort at round 7 with a simultaneous start
      add(1, 0, 0, 0, e_idle(), "abort_accept");
      for (int i = 0; i < 7; i++) add(0, 0, 0, 0, e_run(i, i == 0), "abort_run");
      add(1, 0, 0, 1, e_run(7, 0), "abort_cycle");
      add(0, 0, 0, 0, e_idle(), "abort_idle1");
      add(0, 0, 0, 0, e_idle(), "abort_idle2");
      add(1, 0, 0, 1, e_idle(), "abort_start_idle");
      add(0, 0, 0, 0, e_idle(), "abort_start_ignored");
      // run up to round 9 ahead of an asynchronous reset
      add(1, 0, 0, 0, e_idle(), "rst_accept");
      for (int i = 0; i < 10; i++) add(0, 0, 0, 0, e_run(i, i == 0), "rst_run");
      run_table();
      #1 resetb_i = 1'b0;
      #1 check("async_reset", {select_o, round_o, enable_o, busy_o, ready_o, done_o}, e_idle());
      @(negedge clock_i);
      check("reset_held", {select_o, round_o, enable_o, busy_o, ready_o, done_o}, e_idle());
      #2 resetb_i = 1'b1;
      // single-round instance: one cycle with select and enable, then DONE
      @(posedge clock_i);
      #1 {start_i, mode_i} = 2'b10;
      @(negedge clock_i);
      check("n1_accept", {s1, rd1, e1, b1, r1, d1}, e_idle());
      @(posedge clock_i);
      #1 start_i = 1'b0;
      @(negedge clock_i);
      check("n1_run", {s1, rd1, e1, b1, r1, d1}, e_run(11, 1));
      @(negedge clock_i);
      check("n1_done", {s1, rd1, e1, b1, r1, d1}, e_done());
      @(posedge clock_i);
      #1 abort_i = 1'b1;
      @(posedge clock_i);
      #1 abort_i = 1'b0;
      // p^b after reset recovery
      add(0, 0, 0, 0, e_idle(), "post_idle");
      add(1, 1, 0, 0, e_idle(), "post_accept");
      for (int i = 6; i < 12; i++) add(0, 1, 0, 0, e_run(i, i == 6), "post_run");
      add(0, 0, 0, 0, e_done(), "post_done");
      add(0, 0, 0, 0, e_idle(), "post_idle2");
      run_table();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
